// File: rtl/score_pkg.sv
// Shared types for the score checker: FSM encoding, default widths and the
// result codes understood by the score-tracking and createFace blocks.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RESULT = 2'd3
    } chk_state_t;

    localparam int SCORE_W_DEF = 7;
    localparam int ID_W_DEF    = 3;

    localparam logic [2:0] RES_NONE     = 3'd0;
    localparam logic [2:0] RES_PERSONAL = 3'd1;
    localparam logic [2:0] RES_GLOBAL   = 3'd2;
    localparam logic [2:0] RES_DIED     = 3'd3;
    localparam logic [2:0] RES_TIMEOUT  = 3'd4;

    typedef struct packed {
        logic personal;
        logic global;
        logic timeout;
    } verdict_t;

    // Collapse a verdict plus dead flag into the shared result code.
    function automatic logic [2:0] resCode(input verdict_t v, input logic dead);
        if (v.timeout)                 return RES_TIMEOUT;
        else if (v.global)             return RES_GLOBAL;
        else if (v.personal)           return RES_PERSONAL;
        else if (dead)                 return RES_DIED;
        else                           return RES_NONE;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer;
// the pointer moves one past the grant when adv is asserted.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic          found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant_idx  = IW'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (adv && found)
            ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
    end

endmodule

// File: rtl/multi_score_checker.sv
// Multi-channel score checker: per-channel capture, round-robin grant onto one
// tracker port, result pulses back to the channel. Retry/timeout with SCORE_CHK_TIMEOUT_EN.
module multi_score_checker
    import score_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SCORE_W     = SCORE_W_DEF,
    parameter int ID_W        = ID_W_DEF,
    parameter int TIMEOUT_CYC = 64,
    parameter int MAX_RETRY   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      chk_req,
    input  logic [N_CH*SCORE_W-1:0] chk_score,
    input  logic [N_CH*ID_W-1:0] chk_id,
    input  logic [N_CH-1:0]      chk_guest,
    input  logic [N_CH-1:0]      chk_dead,
    output logic [N_CH-1:0]      chk_busy,
    output logic                 trk_req,
    output logic [SCORE_W-1:0]   trk_score,
    output logic [ID_W-1:0]      trk_id,
    output logic                 trk_guest,
    input  logic                 trk_valid,
    input  logic                 trk_personal,
    input  logic                 trk_global,
    output logic [N_CH-1:0]      res_new_high,
    output logic [N_CH-1:0]      res_global,
    output logic [N_CH-1:0]      res_died,
    output logic [N_CH-1:0]      res_timeout
);

    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    if (N_CH < 2 || N_CH > 8 || TIMEOUT_CYC < 2 || MAX_RETRY < 0) begin : gBadCfg
        $error("multi_score_checker: unsupported parameter set");
    end

    chk_state_t state, nextState;

    logic [N_CH-1:0]              pending, dead, clr;
    logic [N_CH-1:0][SCORE_W-1:0] scoreQ;
    logic [N_CH-1:0][ID_W-1:0]    idQ;
    logic [N_CH-1:0]              guestQ;
    logic [N_CH-1:0]              arbGrant;
    logic [IW-1:0]                arbIdx, gIdx;
    logic                         adv;
    verdict_t                     verdict;
    logic                         retryNow, giveUp;

    assign adv      = (state == IDLE) && (|pending);
    assign clr      = (state == RESULT) ? (N_CH'(1) << gIdx) : '0;
    assign chk_busy = pending;
    assign trk_req  = (state == ISSUE);

    // A request or death event landing in the channel's RESULT cycle beats the clear.
    for (genvar i = 0; i < N_CH; i++) begin : gCh
        always_ff @(posedge clk) begin
            if (rst) begin
                pending[i] <= 1'b0;
                dead[i]    <= 1'b0;
                scoreQ[i]  <= '0;
                idQ[i]     <= '0;
                guestQ[i]  <= 1'b0;
            end else begin
                if (chk_req[i] && (!pending[i] || clr[i])) begin
                    pending[i] <= 1'b1;
                    scoreQ[i]  <= chk_score[i*SCORE_W +: SCORE_W];
                    idQ[i]     <= chk_id[i*ID_W +: ID_W];
                    guestQ[i]  <= chk_guest[i];
                end else if (clr[i]) begin
                    pending[i] <= 1'b0;
                end
                if (chk_dead[i])
                    dead[i] <= 1'b1;
                else if (clr[i])
                    dead[i] <= 1'b0;
            end
        end
    end

    rr_arbiter #(.N(N_CH)) uArb (
        .clk       (clk),
        .rst       (rst),
        .req       (pending),
        .adv       (adv),
        .grant     (arbGrant),
        .grant_idx (arbIdx)
    );

`ifdef SCORE_CHK_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [CW-1:0] waitCnt;
    logic [RW-1:0] retryCnt;
    logic          expire;

    assign expire   = (state == WAIT) && !trk_valid && (waitCnt == CW'(TIMEOUT_CYC - 1));
    assign giveUp   = expire && (retryCnt == RW'(MAX_RETRY));
    assign retryNow = expire && !giveUp;

    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt  <= '0;
            retryCnt <= '0;
        end else begin
            if (state == ISSUE)
                waitCnt <= '0;
            else if (state == WAIT)
                waitCnt <= waitCnt + 1'b1;
            if (adv)
                retryCnt <= '0;
            else if (retryNow)
                retryCnt <= retryCnt + 1'b1;
        end
    end
`else
    assign giveUp   = 1'b0;
    assign retryNow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gIdx      <= '0;
            trk_score <= '0;
            trk_id    <= '0;
            trk_guest <= 1'b0;
            verdict   <= '0;
        end else begin
            state <= nextState;
            // Tracker data is loaded on grant so it holds through retries.
            if (adv) begin
                gIdx      <= arbIdx;
                trk_score <= scoreQ[arbIdx];
                trk_id    <= idQ[arbIdx];
                trk_guest <= guestQ[arbIdx];
            end
            if (state == WAIT && trk_valid)
                verdict <= '{personal: trk_personal, global: trk_global, timeout: 1'b0};
            else if (giveUp)
                verdict <= '{personal: 1'b0, global: 1'b0, timeout: 1'b1};
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (|pending) nextState = ISSUE;
            ISSUE:   nextState = WAIT;
            WAIT: begin
                if (trk_valid)     nextState = RESULT;
                else if (giveUp)   nextState = RESULT;
                else if (retryNow) nextState = ISSUE;
            end
            RESULT:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        res_new_high = '0;
        res_global   = '0;
        res_died     = '0;
        res_timeout  = '0;
        if (state == RESULT) begin
            if (verdict.personal || verdict.global) res_new_high = clr;
            if (verdict.global)                     res_global   = clr;
            if (verdict.timeout)                    res_timeout  = clr;
            else if (!(verdict.personal || verdict.global))
                res_died = clr & dead;
        end
    end

endmodule

// File: tb/tb_multi_score_checker.sv
// Directed bench for multi_score_checker; define SCORE_CHK_TIMEOUT_EN to also
// exercise the retry/timeout path.
module tb_multi_score_checker;

    localparam int N_CH        = 4;
    localparam int SCORE_W     = 7;
    localparam int ID_W        = 3;
    localparam int TIMEOUT_CYC = 8;
    localparam int MAX_RETRY   = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [N_CH-1:0]         chk_req = '0;
    logic [N_CH*SCORE_W-1:0] chk_score = '0;
    logic [N_CH*ID_W-1:0]    chk_id = '0;
    logic [N_CH-1:0]         chk_guest = '0;
    logic [N_CH-1:0]         chk_dead = '0;
    logic [N_CH-1:0]         chk_busy;
    logic                    trk_req;
    logic [SCORE_W-1:0]      trk_score;
    logic [ID_W-1:0]         trk_id;
    logic                    trk_guest;
    logic                    trk_valid = 1'b0;
    logic                    trk_personal = 1'b0;
    logic                    trk_global = 1'b0;
    logic [N_CH-1:0]         res_new_high, res_global, res_died, res_timeout;

    int nChecks = 0;
    int nFails  = 0;
    int cyc     = 0;
    int pulses  = 0;

    multi_score_checker #(
        .N_CH(N_CH), .SCORE_W(SCORE_W), .ID_W(ID_W),
        .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst),
        .chk_req(chk_req), .chk_score(chk_score), .chk_id(chk_id),
        .chk_guest(chk_guest), .chk_dead(chk_dead), .chk_busy(chk_busy),
        .trk_req(trk_req), .trk_score(trk_score), .trk_id(trk_id), .trk_guest(trk_guest),
        .trk_valid(trk_valid), .trk_personal(trk_personal), .trk_global(trk_global),
        .res_new_high(res_new_high), .res_global(res_global),
        .res_died(res_died), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) pulses <= pulses + $countones(res_new_high | res_died | res_timeout);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic postReq(input int ch, input int score, input int id, input bit guest);
        chk_req[ch] = 1'b1;
        chk_score[ch*SCORE_W +: SCORE_W] = SCORE_W'(score);
        chk_id[ch*ID_W +: ID_W] = ID_W'(id);
        chk_guest[ch] = guest;
    endtask

    task automatic waitTrkReq(input string tag, input int maxCyc);
        int n;
        n = 0;
        while (!trk_req && n < maxCyc) begin
            tick();
            n++;
        end
        expectEq(tag, 32'(trk_req), 32'd1);
    endtask

    task automatic answer(input bit p, input bit g);
        trk_valid = 1'b1;
        trk_personal = p;
        trk_global = g;
    endtask

    task automatic quiet();
        trk_valid = 1'b0;
        trk_personal = 1'b0;
        trk_global = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int t0, seen, p0;

        // Reset state
        tick(); tick();
        expectEq("rst_busy", 32'(chk_busy), 0);
        expectEq("rst_trk_req", 32'(trk_req), 0);
        expectEq("rst_trk_score", 32'(trk_score), 0);
        expectEq("rst_res", 32'({res_new_high, res_global, res_died, res_timeout}), 0);
        rst = 1'b0;
        tick();

        // 1: single request on ch2, tracker answers 3 cycles after trk_req
        postReq(2, 55, 3, 1'b1);
        tick();
        chk_req = '0;
        expectEq("t1_busy", 32'(chk_busy), 32'b0100);
        expectEq("t1_no_req_yet", 32'(trk_req), 0);
        tick();
        expectEq("t1_trk_req", 32'(trk_req), 1);
        expectEq("t1_trk_score", 32'(trk_score), 55);
        expectEq("t1_trk_id", 32'(trk_id), 3);
        expectEq("t1_trk_guest", 32'(trk_guest), 1);
        tick();
        expectEq("t1_req_pulse", 32'(trk_req), 0);
        tick(); tick();
        answer(1'b1, 1'b0);
        tick();
        quiet();
        expectEq("t1_new_high", 32'(res_new_high), 32'b0100);
        expectEq("t1_global", 32'(res_global), 0);
        expectEq("t1_died", 32'(res_died), 0);
        expectEq("t1_timeout", 32'(res_timeout), 0);
        tick();
        expectEq("t1_pulse_1cyc", 32'(res_new_high), 0);
        expectEq("t1_busy_clr", 32'(chk_busy), 0);

        // 2: ch1 death then request, no high score
        chk_dead[1] = 1'b1;
        tick();
        chk_dead = '0;
        postReq(1, 10, 5, 1'b0);
        tick();
        chk_req = '0;
        tick();
        expectEq("t2_trk_req", 32'(trk_req), 1);
        expectEq("t2_trk_score", 32'(trk_score), 10);
        tick();
        answer(1'b0, 1'b0);
        tick();
        quiet();
        expectEq("t2_died", 32'(res_died), 32'b0010);
        expectEq("t2_new_high", 32'(res_new_high), 0);
        tick();
        expectEq("t2_busy_clr", 32'(chk_busy), 0);
        expectEq("t2_died_1cyc", 32'(res_died), 0);

        // 3: all channels at once, order must start at ch0 after reset
        doReset();
        for (int i = 0; i < N_CH; i++) postReq(i, 11 + i, i, 1'b0);
        tick();
        chk_req = '0;
        expectEq("t3_busy", 32'(chk_busy), 32'hF);
        p0 = pulses;
        t0 = 0;
        for (int k = 0; k < N_CH; k++) begin
            waitTrkReq($sformatf("t3_trk_req%0d", k), 8);
            expectEq($sformatf("t3_score%0d", k), 32'(trk_score), 32'(11 + k));
            if (k > 0) expectEq($sformatf("t3_gap%0d", k), 32'(cyc - t0), 4);
            t0 = cyc;
            tick();
            answer(k != 3, k == 3);
            tick();
            quiet();
            expectEq($sformatf("t3_high%0d", k), 32'(res_new_high), 32'(1 << k));
            expectEq($sformatf("t3_glob%0d", k), 32'(res_global), (k == 3) ? 32'b1000 : 0);
        end
        tick();
        expectEq("t3_pulse_count", 32'(pulses - p0), 4);
        expectEq("t3_busy_clr", 32'(chk_busy), 0);

        // 4: repeat request while busy is dropped; trk_valid in ISSUE ignored
        postReq(0, 20, 1, 1'b0);
        tick();
        postReq(0, 9, 2, 1'b1);
        tick();
        chk_req = '0;
        expectEq("t4_trk_req", 32'(trk_req), 1);
        expectEq("t4_trk_score", 32'(trk_score), 20);
        expectEq("t4_trk_id", 32'(trk_id), 1);
        answer(1'b1, 1'b0);
        tick();
        quiet();
        expectEq("t4_issue_valid_ignored", 32'(res_new_high), 0);
        expectEq("t4_still_busy", 32'(chk_busy), 32'b0001);
        answer(1'b0, 1'b1);
        tick();
        quiet();
        expectEq("t4_new_high", 32'(res_new_high), 32'b0001);
        expectEq("t4_global", 32'(res_global), 32'b0001);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen += int'(trk_req);
        end
        expectEq("t4_dropped", 32'(seen), 0);
        expectEq("t4_busy_clr", 32'(chk_busy), 0);

        // 6: reset while in WAIT abandons the transaction
        postReq(3, 77, 6, 1'b1);
        tick();
        chk_req = '0;
        tick();
        expectEq("t6_trk_req", 32'(trk_req), 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expectEq("t6_busy", 32'(chk_busy), 0);
        expectEq("t6_trk", 32'({trk_req, trk_score, trk_id, trk_guest}), 0);
        expectEq("t6_res", 32'({res_new_high, res_global, res_died, res_timeout}), 0);
        answer(1'b1, 1'b1);
        tick();
        quiet();
        expectEq("t6_late_valid", 32'({res_new_high, res_global, res_died, res_timeout}), 0);
        tick();
        expectEq("t6_idle", 32'({trk_req, res_new_high}), 0);

`ifdef SCORE_CHK_TIMEOUT_EN
        // 5: silent tracker -> 2 retries then timeout; dead flag gives no died pulse
        chk_dead[2] = 1'b1;
        postReq(2, 33, 4, 1'b0);
        tick();
        chk_req = '0;
        chk_dead = '0;
        waitTrkReq("t5_req0", 4);
        expectEq("t5_score0", 32'(trk_score), 33);
        t0 = cyc;
        for (int r = 1; r <= MAX_RETRY; r++) begin
            tick();
            waitTrkReq($sformatf("t5_req%0d", r), 16);
            expectEq($sformatf("t5_gap%0d", r), 32'(cyc - t0), 32'(TIMEOUT_CYC + 1));
            expectEq($sformatf("t5_score%0d", r), 32'(trk_score), 33);
            t0 = cyc;
        end
        seen = 0;
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            tick();
            seen += int'(trk_req) + $countones(res_timeout);
        end
        expectEq("t5_quiet_wait", 32'(seen), 0);
        tick();
        expectEq("t5_timeout", 32'(res_timeout), 32'b0100);
        expectEq("t5_no_died", 32'(res_died), 0);
        expectEq("t5_no_high", 32'(res_new_high), 0);
        tick();
        expectEq("t5_busy_clr", 32'(chk_busy), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
